rst_sync: RTL and testbench

RST_SYNC -- requirements
Module: rst_sync

---
 rtl/rst_sync_pkg.sv | 11 +
 rtl/rst_sync_ff.sv | 32 +++
 rtl/rst_sync.sv | 48 ++++
 tb/tb_rst_sync.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/rst_sync_pkg.sv
// Shared constants for the reset release synchronizer.
// Latency: n/a (constants only).
// Backpressure: n/a.
package rst_sync_pkg;

    // Legal and default depth of the release chain.
    localparam int STAGES_MIN = 2;
    localparam int STAGES_MAX = 8;
    localparam int STAGES_DEF = 2;

endpackage : rst_sync_pkg

// File: rtl/rst_sync_ff.sv
// Single synchronizer flop: D register with synchronous active-low clear.
// Latency: 1 rising edge from d_i/clr_n_i to q_o.
// Backpressure: none; samples every rising edge.
//
// Ports:
//   clk_i   - clock, rising edge active
//   clr_n_i - synchronous clear, 0 = clear q to 0
//   d_i     - data loaded when not clearing
//   q_o     - registered output
module rst_sync_ff (
    input  logic clk_i,
    input  logic clr_n_i,
    input  logic d_i,
    output logic q_o
);

    // Keep each chain flop distinct and in place: merging or retiming them
    // would shorten the effective release chain.
    (* async_reg = "true", dont_touch = "true", keep = "true" *)
    logic q_q;

    always_ff @(posedge clk_i) begin
        if (!clr_n_i) begin
            q_q <= 1'b0;
        end else begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule : rst_sync_ff

// File: rtl/rst_sync.sv
// Reset conditioner: immediate (1-edge) assertion, `stages`-edge release.
// Latency: assert 1 edge after rst sampled 0; release after `stages` edges of rst==1.
// Backpressure: none; free-running on every rising clk edge.
//
// Ports:
//   clk      - single clock, rising edge active
//   rst      - reset request, synchronous, active-low
//   sync_rst - conditioned reset, active-low, straight from last chain flop
module rst_sync
    import rst_sync_pkg::*;
#(
    parameter int stages = STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    output logic sync_rst
);

    // Reject illegal chain depths at elaboration time.
    if (stages < STAGES_MIN || stages > STAGES_MAX) begin : g_bad_stages
        $fatal(1, "rst_sync: stages=%0d outside legal range %0d..%0d",
               stages, STAGES_MIN, STAGES_MAX);
    end

    logic [stages-1:0] chain_q;

    // A 1 is shifted in from the head; every flop is cleared together when
    // rst is sampled low, so any low sample restarts the count from zero.
    for (genvar i = 0; i < stages; i++) begin : g_chain
        logic d;
        if (i == 0) begin : g_head
            assign d = 1'b1;
        end else begin : g_body
            assign d = chain_q[i-1];
        end

        rst_sync_ff u_ff (
            .clk_i   (clk),
            .clr_n_i (rst),
            .d_i     (d),
            .q_o     (chain_q[i])
        );
    end

    // Output comes straight from a flop, so it can only change after an edge.
    assign sync_rst = chain_q[stages-1];

endmodule : rst_sync

// File: tb/tb_rst_sync.sv
// Testbench for rst_sync: two instances (stages=2 and stages=4) share rst.
// Latency: n/a.
// Backpressure: n/a.
module tb_rst_sync;

    logic clk;
    logic rst;
    logic sync_rst_2;
    logic sync_rst_4;

    int checks   = 0;
    int failures = 0;

    rst_sync #(.stages(2)) u_dut2 (
        .clk      (clk),
        .rst      (rst),
        .sync_rst (sync_rst_2)
    );

    rst_sync #(.stages(4)) u_dut4 (
        .clk      (clk),
        .rst      (rst),
        .sync_rst (sync_rst_4)
    );

    // Clock starts high; rising edges at 10, 20, 30, ...
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic rst;
        logic e2;
        logic e4;
    } vec_t;

    typedef struct {
        logic  e2;
        logic  e4;
        string name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic add(input logic r, input logic e2, input logic e4);
        vec_t v;
        v.rst = r;
        v.e2  = e2;
        v.e4  = e4;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    // Pop one scoreboard entry and compare both instances against it.
    task automatic pop_compare();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty: got 0 entries expected >=1 at t=%0t", $time);
        end else begin
            e = sb.pop_front();
            check({e.name, "/s2"}, sync_rst_2, e.e2);
            check({e.name, "/s4"}, sync_rst_4, e.e4);
        end
    endtask

    task automatic push_exp(input logic e2, input logic e4, input string name);
        exp_t e;
        e.e2   = e2;
        e.e4   = e4;
        e.name = name;
        sb.push_back(e);
    endtask

    initial begin
        rst = 1'b1;

        // Initial reset: low across the edge at 10, then release.
        add(0, 0, 0);                      // edge 10: assert
        add(1, 0, 0);                      // edge 20
        add(1, 1, 0);                      // edge 30: stages=2 released
        add(1, 1, 0);                      // edge 40
        add(1, 1, 1);                      // edge 50: stages=4 released
        for (int k = 0; k < 8; k++) add(1, 1, 1);   // edges 60..130 stay high
        // Single high edge, then low again: release restarts.
        add(0, 0, 0);
        add(1, 0, 0);
        add(0, 0, 0);
        add(1, 0, 0);
        add(1, 1, 0);
        add(1, 1, 0);
        add(1, 1, 1);
        // Abort a stages=4 release after three high edges.
        add(0, 0, 0);
        add(1, 0, 0);
        add(1, 1, 0);
        add(1, 1, 0);
        add(0, 0, 0);
        // Long reset: ten low cycles, then exact release counts.
        for (int k = 0; k < 10; k++) add(0, 0, 0);
        add(1, 0, 0);
        add(1, 1, 0);
        add(1, 1, 0);
        add(1, 1, 1);
        add(1, 1, 1);

        // Drive each vector before its edge, compare just after it.
        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst;
            push_exp(vecs[i].e2, vecs[i].e4, $sformatf("vec%0d", i));
            @(posedge clk);
            #1;
            pop_compare();
        end

        // Short low pulse between edges while released: ignored, and the
        // output never follows rst combinationally.
        #1;
        rst = 1'b0;
        #1;
        check("pulse_mid/s2", sync_rst_2, 1'b1);
        check("pulse_mid/s4", sync_rst_4, 1'b1);
        #2;
        rst = 1'b1;
        push_exp(1, 1, "pulse_after");
        @(posedge clk);
        #1;
        pop_compare();

        // Low mid-cycle held across the edge: asserts on that edge only.
        #2;
        rst = 1'b0;
        #1;
        check("assert_pre/s2", sync_rst_2, 1'b1);
        check("assert_pre/s4", sync_rst_4, 1'b1);
        push_exp(0, 0, "assert_edge");
        @(posedge clk);
        #1;
        pop_compare();

        // Release again with rst changing just after an edge.
        rst = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            push_exp((k >= 2), (k >= 4), $sformatf("rel%0d", k));
            @(posedge clk);
            #1;
            pop_compare();
        end

        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_rst_sync
